// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic array sweep controller.
package systolic_ctrl_pkg;

    localparam int ROW_DEF      = 4;
    localparam int COLUMN_DEF   = 9;
    localparam int SETTLE_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} ctrlState_t;

    // A programmed settle time of zero still needs one cycle for the array to settle.
    function automatic int unsigned settle_eff(input int unsigned cfg);
        return (cfg == 0) ? 1 : cfg;
    endfunction

endpackage

// File: rtl/systolic_settle_timer.sv
// Settle down-counter: load N, expire is high on the cycle the count reaches 1.
module systolic_settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] n,
    output logic         expire
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    // Parks at zero once drained so a stale count never looks like an expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (load)         cnt <= n;
        else if (cnt != '0)    cnt <= cnt - ONE;
    end

    assign expire = (cnt == ONE);

endmodule

// File: rtl/systolic_sweep_ctrl.sv
// Sequencer for the ROW x COLUMN NOR array: single-shot requests or a full input sweep.
module systolic_sweep_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int ROW      = ROW_DEF,
    parameter int COLUMN   = COLUMN_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SETTLE_W-1:0]   cfg_settle,
    input  logic                  cfg_sweep,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ROW-1:0]        req_row,
    input  logic [COLUMN-1:0]     req_col,
    output logic [ROW-1:0]        arr_row,
    output logic [COLUMN-1:0]     arr_col,
    input  logic                  arr_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_out,
    output logic [ROW-1:0]        rsp_row,
    output logic [COLUMN-1:0]     rsp_col,
    output logic                  busy,
    output logic                  done,
    output logic [ROW+COLUMN:0]   ones_count
);

    localparam int VW = ROW + COLUMN;
    localparam logic [VW-1:0] LAST_IDX = '1;
    localparam logic [VW-1:0] VEC_ONE  = VW'(1);
    localparam logic [VW:0]   ONES_ONE = (VW+1)'(1);
    localparam logic [VW:0]   ONES_MAX = {1'b1, {VW{1'b0}}};

    ctrlState_t state, stateNext;

    logic [VW-1:0]       vecQ, rspVecQ;
    logic [SETTLE_W-1:0] nQ, nEff, tmrN;
    logic [VW:0]         onesQ;
    logic                sweepQ, rspValidQ, rspOutQ, doneQ;
    logic                accept, launch, capture, handshake, advance, finish, abortAct;
    logic                tmrLoad, expire;

    assign nEff = SETTLE_W'(settle_eff(32'(cfg_settle)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // abort is checked first so it wins over both settle expiry and a response handshake.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        launch    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        abortAct  = 1'b0;
        case (state)
            IDLE: begin
                if (!cfg_sweep && req_valid) begin
                    accept    = 1'b1;
                    stateNext = SETTLE;
                end else if (cfg_sweep && start) begin
                    launch    = 1'b1;
                    stateNext = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    abortAct  = 1'b1;
                    stateNext = IDLE;
                end else if (expire) begin
                    capture   = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (abort) begin
                    abortAct  = 1'b1;
                    stateNext = IDLE;
                end else if (rsp_ready) begin
                    handshake = 1'b1;
                    if (!sweepQ) begin
                        stateNext = IDLE;
                    end else if (vecQ == LAST_IDX) begin
                        finish    = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        advance   = 1'b1;
                        stateNext = SETTLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // The launch-time N is reused for every vector of a sweep.
    assign tmrLoad = accept | launch | advance;
    assign tmrN    = (state == IDLE) ? nEff : nQ;

    systolic_settle_timer #(.W(SETTLE_W)) uTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmrLoad),
        .n      (tmrN),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vecQ      <= '0;
            nQ        <= '0;
            sweepQ    <= 1'b0;
            rspVecQ   <= '0;
            rspOutQ   <= 1'b0;
            rspValidQ <= 1'b0;
            onesQ     <= '0;
            doneQ     <= 1'b0;
        end else begin
            if (accept) begin
                vecQ   <= {req_row, req_col};
                nQ     <= nEff;
                sweepQ <= 1'b0;
            end else if (launch) begin
                vecQ   <= '0;
                nQ     <= nEff;
                sweepQ <= 1'b1;
            end else if (advance) begin
                vecQ   <= vecQ + VEC_ONE;
            end

            if (capture) begin
                rspOutQ <= arr_out;
                rspVecQ <= vecQ;
            end

            if (capture)                     rspValidQ <= 1'b1;
            else if (handshake || abortAct)  rspValidQ <= 1'b0;

            if (launch)
                onesQ <= '0;
            else if (handshake && sweepQ && rspOutQ && (onesQ != ONES_MAX))
                onesQ <= onesQ + ONES_ONE;

            doneQ <= finish;
        end
    end

    assign req_ready  = (state == IDLE) && !cfg_sweep;
    assign busy       = (state != IDLE);
    assign arr_row    = vecQ[VW-1:COLUMN];
    assign arr_col    = vecQ[COLUMN-1:0];
    assign rsp_valid  = rspValidQ;
    assign rsp_out    = rspOutQ;
    assign rsp_row    = rspVecQ[VW-1:COLUMN];
    assign rsp_col    = rspVecQ[COLUMN-1:0];
    assign done       = doneQ;
    assign ones_count = onesQ;

endmodule

// File: tb/tb_systolic_sweep_ctrl.sv
// Randomized + directed bench: a 2x2 and a 4x9 controller share stimulus, checked against a transaction model.
module tb_systolic_sweep_ctrl;

    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [SW-1:0] cfgSettle;
    logic          cfgSweep, start, abort, reqValid, rspReady, useNor;
    logic [3:0]    reqRow;
    logic [8:0]    reqCol;

    logic       sReqReady, sArrOut, sRspValid, sRspOut, sBusy, sDone;
    logic [1:0] sArrRow, sArrCol, sRspRow, sRspCol;
    logic [4:0] sOnes;

    logic        bReqReady, bArrOut, bRspValid, bRspOut, bBusy, bDone;
    logic [3:0]  bArrRow, bRspRow;
    logic [8:0]  bArrCol, bRspCol;
    logic [13:0] bOnes;

    int nCmp = 0;
    int nErr = 0;

    // Grid of NOR cells: row bits enter from the left, column bits from the top.
    function automatic logic norArr(input logic [3:0] r, input logic [8:0] c);
        logic g [4][9];
        logic h, u;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 9; j++) begin
                if (j == 0) h = r[i]; else h = g[i][j-1];
                if (i == 0) u = c[j]; else u = g[i-1][j];
                g[i][j] = ~(h | u);
            end
        return g[3][8];
    endfunction

    assign sArrOut = ^{sArrRow, sArrCol};
    assign bArrOut = useNor ? norArr(bArrRow, bArrCol) : ^{bArrRow, bArrCol};

    systolic_sweep_ctrl #(.ROW(2), .COLUMN(2), .SETTLE_W(SW)) dutS (
        .clk(clk), .rst_n(rst_n), .cfg_settle(cfgSettle), .cfg_sweep(cfgSweep),
        .start(start), .abort(abort), .req_valid(reqValid), .req_ready(sReqReady),
        .req_row(reqRow[1:0]), .req_col(reqCol[1:0]), .arr_row(sArrRow), .arr_col(sArrCol),
        .arr_out(sArrOut), .rsp_valid(sRspValid), .rsp_ready(rspReady), .rsp_out(sRspOut),
        .rsp_row(sRspRow), .rsp_col(sRspCol), .busy(sBusy), .done(sDone), .ones_count(sOnes)
    );

    systolic_sweep_ctrl #(.ROW(4), .COLUMN(9), .SETTLE_W(SW)) dutB (
        .clk(clk), .rst_n(rst_n), .cfg_settle(cfgSettle), .cfg_sweep(cfgSweep),
        .start(start), .abort(abort), .req_valid(reqValid), .req_ready(bReqReady),
        .req_row(reqRow), .req_col(reqCol), .arr_row(bArrRow), .arr_col(bArrCol),
        .arr_out(bArrOut), .rsp_valid(bRspValid), .rsp_ready(rspReady), .rsp_out(bRspOut),
        .rsp_row(bRspRow), .rsp_col(bRspCol), .busy(bBusy), .done(bDone), .ones_count(bOnes)
    );

    // Index 0 = 2x2 instance, 1 = 4x9 instance, widened to 13-bit vectors.
    logic [12:0] oArr[2], oRspV[2];
    logic [13:0] oOnes[2];
    logic        oRspOut[2], oRspValid[2], oReqReady[2], oBusy[2], oDone[2];

    always_comb begin
        oArr[0] = {9'd0, sArrRow, sArrCol};  oArr[1] = {bArrRow, bArrCol};
        oRspV[0] = {9'd0, sRspRow, sRspCol}; oRspV[1] = {bRspRow, bRspCol};
        oOnes[0] = {9'd0, sOnes};            oOnes[1] = bOnes;
        oRspOut[0] = sRspOut;     oRspOut[1] = bRspOut;
        oRspValid[0] = sRspValid; oRspValid[1] = bRspValid;
        oReqReady[0] = sReqReady; oReqReady[1] = bReqReady;
        oBusy[0] = sBusy;         oBusy[1] = bBusy;
        oDone[0] = sDone;         oDone[1] = bDone;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] vwMask(input int d);
        return (d == 0) ? 13'h000F : 13'h1FFF;
    endfunction

    function automatic logic [12:0] reqVecOf(input int d);
        return (d == 0) ? {9'd0, reqRow[1:0], reqCol[1:0]} : {reqRow, reqCol};
    endfunction

    function automatic logic arrFn(input int d, input logic [12:0] v);
        if (d == 0) return ^v[3:0];
        return useNor ? norArr(v[12:9], v[8:0]) : ^v;
    endfunction

    // Transaction model: a response is due N cycles after the edge that loaded the vector.
    int          cyc;
    logic        mBusy[2], mRspValid[2], mSweep[2], mDone[2], mRspOut[2];
    logic [12:0] mVec[2];
    int          mN[2], mDue[2], mOnes[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            for (int d = 0; d < 2; d++) begin
                mBusy[d] = 0; mRspValid[d] = 0; mSweep[d] = 0; mDone[d] = 0; mRspOut[d] = 0;
                mVec[d] = '0; mN[d] = 1; mDue[d] = 0; mOnes[d] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int d = 0; d < 2; d++) begin
                mDone[d] = 0;
                if (!mBusy[d]) begin
                    if (!cfgSweep && reqValid) begin
                        mVec[d] = reqVecOf(d); mSweep[d] = 0;
                        mN[d] = (cfgSettle == 0) ? 1 : int'(cfgSettle);
                        mDue[d] = cyc + mN[d]; mBusy[d] = 1;
                    end else if (cfgSweep && start) begin
                        mVec[d] = '0; mSweep[d] = 1; mOnes[d] = 0;
                        mN[d] = (cfgSettle == 0) ? 1 : int'(cfgSettle);
                        mDue[d] = cyc + mN[d]; mBusy[d] = 1;
                    end
                end else if (abort) begin
                    mBusy[d] = 0; mRspValid[d] = 0;
                end else if (!mRspValid[d]) begin
                    if (cyc == mDue[d]) begin
                        mRspValid[d] = 1; mRspOut[d] = arrFn(d, mVec[d]);
                    end
                end else if (rspReady) begin
                    mRspValid[d] = 0;
                    if (mSweep[d]) mOnes[d] = mOnes[d] + int'(mRspOut[d]);
                    if (!mSweep[d]) mBusy[d] = 0;
                    else if (mVec[d] == vwMask(d)) begin
                        mBusy[d] = 0; mDone[d] = 1;
                    end else begin
                        mVec[d] = mVec[d] + 13'd1; mDue[d] = cyc + mN[d];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy[%0d]", d), 32'(oBusy[d]), 32'(mBusy[d]));
                chk($sformatf("req_ready[%0d]", d), 32'(oReqReady[d]), 32'(!mBusy[d] && !cfgSweep));
                chk($sformatf("rsp_valid[%0d]", d), 32'(oRspValid[d]), 32'(mRspValid[d]));
                chk($sformatf("done[%0d]", d), 32'(oDone[d]), 32'(mDone[d]));
                chk($sformatf("ones[%0d]", d), 32'(oOnes[d]), 32'(mOnes[d]));
                chk($sformatf("arr[%0d]", d), 32'(oArr[d]), 32'(mVec[d]));
                if (mRspValid[d]) begin
                    chk($sformatf("rsp_vec[%0d]", d), 32'(oRspV[d]), 32'(mVec[d]));
                    chk($sformatf("rsp_out[%0d]", d), 32'(oRspOut[d]), 32'(mRspOut[d]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkZero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_arr"}, 32'(oArr[d]), 32'd0);
            chk({tag, "_rsp_vec"}, 32'(oRspV[d]), 32'd0);
            chk({tag, "_rsp_valid"}, 32'(oRspValid[d]), 32'd0);
            chk({tag, "_rsp_out"}, 32'(oRspOut[d]), 32'd0);
            chk({tag, "_busy"}, 32'(oBusy[d]), 32'd0);
            chk({tag, "_done"}, 32'(oDone[d]), 32'd0);
            chk({tag, "_ones"}, 32'(oOnes[d]), 32'd0);
        end
    endtask

    // Follows one instance through a sweep with rsp_ready held high; budget bounds the wait.
    task automatic runSweep(input string tag, input int d, input int expRsp, input int expOnes,
                            input int budget);
        int nRsp = 0;
        int nDone = 0;
        for (int c = 0; c < budget && nDone == 0; c++) begin
            @(negedge clk);
            if (oRspValid[d]) begin
                chk({tag, "_order"}, 32'(oRspV[d]), 32'(nRsp));
                nRsp++;
            end
            if (oDone[d]) begin
                nDone++;
                chk({tag, "_ones_at_done"}, 32'(oOnes[d]), 32'(expOnes));
            end
        end
        chk({tag, "_count"}, 32'(nRsp), 32'(expRsp));
        chk({tag, "_done_seen"}, 32'(nDone), 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(oDone[d]), 32'd0);
        chk({tag, "_idle"}, 32'(oBusy[d]), 32'd0);
    endtask

    task automatic abortAll();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        int norTotal;
        int budget;

        rst_n = 1'b0; cfgSettle = '0; cfgSweep = 1'b0; start = 1'b0; abort = 1'b0;
        reqValid = 1'b0; rspReady = 1'b0; useNor = 1'b0; reqRow = '0; reqCol = '0;

        repeat (3) tick();
        chkZero("rst_hold");
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chkZero("rst_rel");
        chk("rst_req_ready", 32'(oReqReady[1]), 32'd1);

        // Single-shot, settle 3: valid appears on the third edge after acceptance.
        cfgSettle = 8'd3; reqRow = 4'b0001; reqCol = 9'd0; reqValid = 1'b1;
        tick();
        reqValid = 1'b0; cfgSettle = 8'd7;
        tick(); tick();
        @(negedge clk);
        chk("ss3_early", 32'(oRspValid[1]), 32'd0);
        tick();
        @(negedge clk);
        chk("ss3_valid", 32'(oRspValid[1]), 32'd1);
        chk("ss3_out", 32'(oRspOut[1]), 32'd1);
        chk("ss3_out_s", 32'(oRspOut[0]), 32'd1);

        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("bp_rsp_row", 32'(bRspRow), 32'd1);
            chk("bp_rsp_col", 32'(bRspCol), 32'd0);
            chk("bp_arr", 32'(oArr[1]), 32'h200);
            chk("bp_req_ready", 32'(oReqReady[1]), 32'd0);
        end
        rspReady = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_release_idle", 32'(oBusy[1]), 32'd0);
        rspReady = 1'b0;

        // Settle 0 behaves as 1.
        cfgSettle = 8'd0; reqRow = 4'b1010; reqCol = 9'h0F3; reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        @(negedge clk);
        chk("ss0_early", 32'(oRspValid[1]), 32'd0);
        tick();
        @(negedge clk);
        chk("ss0_valid", 32'(oRspValid[1]), 32'd1);
        chk("ss0_out", 32'(oRspOut[1]), 32'd0);
        chk("ss0_out_s", 32'(oRspOut[0]), 32'd1);
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;

        // Random single-shot traffic with backpressure and occasional abort.
        for (int i = 0; i < 400; i++) begin
            reqValid  = 1'($urandom_range(0, 1));
            reqRow    = 4'($urandom);
            reqCol    = 9'($urandom);
            cfgSettle = 8'($urandom_range(0, 5));
            rspReady  = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 24) == 0);
            start     = 1'($urandom_range(0, 1));
            tick();
        end

        // Mixed modes: sweep launches interleaved with requests and aborts.
        for (int i = 0; i < 600; i++) begin
            reqValid  = 1'($urandom_range(0, 1));
            reqRow    = 4'($urandom);
            reqCol    = 9'($urandom);
            cfgSettle = 8'($urandom_range(0, 3));
            cfgSweep  = ($urandom_range(0, 3) == 0);
            rspReady  = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 39) == 0);
            start     = ($urandom_range(0, 3) == 0);
            tick();
        end
        reqValid = 1'b0; start = 1'b0; cfgSweep = 1'b0; rspReady = 1'b0;
        abortAll();
        tick();

        // 2x2 sweep: 16 in-order responses, ones_count = 8 for parity.
        cfgSweep = 1'b1; cfgSettle = 8'd2; rspReady = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        runSweep("sweep", 0, 16, 8, 200);
        abortAll();

        // Abort while a response is pending, then a clean restart.
        cfgSettle = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rspReady = 1'b0;
        budget = 0;
        @(negedge clk);
        while (!oRspValid[0] && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        chk("ab_reach_resp", 32'(oRspValid[0]), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("ab_busy", 32'(oBusy[0]), 32'd0);
        chk("ab_valid", 32'(oRspValid[0]), 32'd0);
        chk("ab_done", 32'(oDone[0]), 32'd0);
        rspReady = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("rs_ones_clear", 32'(oOnes[0]), 32'd0);
        runSweep("restart", 0, 16, 8, 200);
        abortAll();

        // Asynchronous reset while settling.
        cfgSweep = 1'b0; cfgSettle = 8'd10; reqRow = 4'hF; reqCol = 9'h1AB; reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        tick();
        chk("pre_rst_busy", 32'(oBusy[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1 chkZero("rst_async");
        tick();
        rst_n = 1'b1;
        tick();

        // Full 4x9 sweep through the NOR array.
        norTotal = 0;
        for (int v = 0; v < 8192; v++) begin
            logic [12:0] vv;
            vv = 13'(v);
            norTotal += int'(norArr(vv[12:9], vv[8:0]));
        end
        useNor = 1'b1; cfgSweep = 1'b1; cfgSettle = 8'd0; rspReady = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        runSweep("nor", 1, 8192, norTotal, 20000);
        cfgSweep = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
